// File: rtl/io_register_bank.sv
// Register bank: constants V0/V1, general registers and FIFO-backed I/O channels
// behind two combinational read ports and one write port.

module io_register_bank_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Flags come from registered count only, so a full FIFO refuses a push
  // even when a pop happens in the same cycle.
  always_comb begin
    empty = (cnt_q == '0);
    full  = (cnt_q == CNT_W'(DEPTH));
    head  = mem_q[rptr_q];
  end

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module io_register_bank #(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned NUM_GPR    = 2,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ADDR_W     = $clog2(2 + NUM_GPR + NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_valid,
  input  logic [ADDR_W-1:0]             rd_addr_a,
  input  logic [ADDR_W-1:0]             rd_addr_b,
  output logic                          rd_ready,
  output logic [WORD_SIZE-1:0]          rd_data_a,
  output logic [WORD_SIZE-1:0]          rd_data_b,
  input  logic                          wr_valid,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [WORD_SIZE-1:0]          wr_data,
  output logic                          wr_ready,
  input  logic [NUM_PORTS-1:0]          rx_valid,
  input  logic [NUM_PORTS*WORD_SIZE-1:0] rx_data,
  output logic [NUM_PORTS-1:0]          rx_ready,
  output logic [NUM_PORTS-1:0]          tx_valid,
  output logic [NUM_PORTS*WORD_SIZE-1:0] tx_data,
  input  logic [NUM_PORTS-1:0]          tx_ready
);
  localparam int unsigned PORT_BASE = 2 + NUM_GPR;

  logic [WORD_SIZE-1:0] gpr_q [NUM_GPR];
  logic [WORD_SIZE-1:0] gpr_d [NUM_GPR];
  logic [WORD_SIZE-1:0] rx_head [NUM_PORTS];
  logic [NUM_PORTS-1:0] sel_a, sel_b, sel_w;
  logic [NUM_PORTS-1:0] rx_empty, rx_full, tx_empty, tx_full;
  logic [NUM_PORTS-1:0] rx_push, rx_pop, tx_push, tx_pop;
  logic                 rd_fire, wr_fire;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_w = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      sel_a[k] = (rd_addr_a == ADDR_W'(PORT_BASE + k));
      sel_b[k] = (rd_addr_b == ADDR_W'(PORT_BASE + k));
      sel_w[k] = (wr_addr == ADDR_W'(PORT_BASE + k));
    end
  end

  // A port named by both operands is OR-ed into one pop.
  always_comb begin
    rd_ready = ~|((sel_a | sel_b) & rx_empty);
    rd_fire  = rd_valid && rd_ready;
    rx_pop   = (sel_a | sel_b) & {NUM_PORTS{rd_fire}};
    wr_ready = ~|(sel_w & tx_full);
    wr_fire  = wr_valid && wr_ready;
    tx_push  = sel_w & {NUM_PORTS{wr_fire}};
    rx_ready = ~rx_full;
    rx_push  = rx_valid & rx_ready;
    tx_valid = ~tx_empty;
    tx_pop   = tx_valid & tx_ready;
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a == ADDR_W'(1)) rd_data_a = WORD_SIZE'(1);
    if (rd_addr_b == ADDR_W'(1)) rd_data_b = WORD_SIZE'(1);
    for (int unsigned g = 0; g < NUM_GPR; g++) begin
      if (rd_addr_a == ADDR_W'(2 + g)) rd_data_a = gpr_q[g];
      if (rd_addr_b == ADDR_W'(2 + g)) rd_data_b = gpr_q[g];
    end
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (sel_a[k]) rd_data_a = rx_head[k];
      if (sel_b[k]) rd_data_b = rx_head[k];
    end
  end

  always_comb begin
    gpr_d = gpr_q;
    for (int unsigned g = 0; g < NUM_GPR; g++) begin
      if (wr_fire && (wr_addr == ADDR_W'(2 + g))) gpr_d[g] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gpr_q <= '{default: '0};
    else     gpr_q <= gpr_d;
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_chan
    io_register_bank_fifo #(
      .WIDTH(WORD_SIZE),
      .DEPTH(FIFO_DEPTH)
    ) u_rx (
      .clk      (clk),
      .rst      (rst),
      .push     (rx_push[k]),
      .push_data(rx_data[k*WORD_SIZE +: WORD_SIZE]),
      .pop      (rx_pop[k]),
      .head     (rx_head[k]),
      .empty    (rx_empty[k]),
      .full     (rx_full[k])
    );

    io_register_bank_fifo #(
      .WIDTH(WORD_SIZE),
      .DEPTH(FIFO_DEPTH)
    ) u_tx (
      .clk      (clk),
      .rst      (rst),
      .push     (tx_push[k]),
      .push_data(wr_data),
      .pop      (tx_pop[k]),
      .head     (tx_data[k*WORD_SIZE +: WORD_SIZE]),
      .empty    (tx_empty[k]),
      .full     (tx_full[k])
    );
  end
endmodule

// File: doc/io_register_bank.md
Name: io_register_bank

Overview:
- Parametrised successor to the CPU's register set: constant registers, general registers and memory-mapped I/O channel registers behind one addressed interface.
- Two combinational read ports feed ALU operands a/b; one write port takes writeback.
- Each I/O channel has a receive FIFO and a transmit FIFO with valid/ready handshakes, so the core stalls on empty or full channels instead of losing data.

Parameters:
- WORD_SIZE, 8, data width in bits.
- NUM_GPR, 2, general registers (RA, R1, ...), minimum 1.
- NUM_PORTS, 4, I/O channels (P1..Pn), minimum 1.
- FIFO_DEPTH, 2, entries per RX and per TX FIFO, power of two, minimum 2.
- ADDR_W, $clog2(2+NUM_GPR+NUM_PORTS), register address width (3 at defaults).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_valid  in  1  core requests operands this cycle.
- rd_addr_a  in  ADDR_W  operand A register address.
- rd_addr_b  in  ADDR_W  operand B register address.
- rd_ready  out  1  both operands available; a read is consumed on rd_valid&&rd_ready.
- rd_data_a  out  WORD_SIZE  operand A value.
- rd_data_b  out  WORD_SIZE  operand B value.
- wr_valid  in  1  writeback request.
- wr_addr  in  ADDR_W  destination register.
- wr_data  in  WORD_SIZE  writeback value.
- wr_ready  out  1  write accepted on wr_valid&&wr_ready.
- rx_valid  in  NUM_PORTS  per-channel inbound valid.
- rx_data  in  NUM_PORTS*WORD_SIZE  inbound words, channel k at bits [k*WORD_SIZE +: WORD_SIZE].
- rx_ready  out  NUM_PORTS  per-channel inbound ready.
- tx_valid  out  NUM_PORTS  per-channel outbound valid.
- tx_data  out  NUM_PORTS*WORD_SIZE  outbound words, same packing.
- tx_ready  in  NUM_PORTS  per-channel outbound ready.

Behaviour:
- Address map:
  - 0 = V0, reads constant 0.
  - 1 = V1, reads constant 1.
  - 2..1+NUM_GPR = GPRs.
  - next NUM_PORTS addresses = P1..Pn.
  - Addresses above the map read 0, always ready; writes to them are accepted and discarded.
- Reset (async assert, sync-release use): all GPRs = 0, all FIFOs empty.
  - Outputs during reset: tx_valid = 0, rx_ready = all 1s.
  - rd_ready reflects the empty state: 0 if any addressed operand is a port, else 1.
  - wr_ready = 1.
- Reads:
  - Combinational, zero latency.
  - A port operand returns its RX FIFO head.
  - rd_ready = 0 if any addressed port RX FIFO is empty.
  - On a consumed read, each addressed port pops exactly once. If A and B name the same port, both get the same head and only one pop occurs.
  - rd_data is don't-care while rd_ready = 0; the bench must not check it.
- Writes:
  - A GPR write lands at the clock edge and is visible to reads the next cycle. No same-cycle bypass: a read and write of the same GPR in one cycle returns the old value.
  - V0/V1 writes are accepted and discarded.
  - Port writes push the TX FIFO. wr_ready = 0 only when the addressed TX FIFO is full.
  - A port read and a port write in the same cycle are independent (RX vs TX).
- Channel side:
  - rx_ready[k] = RX FIFO k not full. A push occurs on rx_valid&&rx_ready; the word is readable the next cycle.
  - tx_valid[k] = TX FIFO k not empty; tx_data = head; pop on tx_valid&&tx_ready.
  - A write pushed at edge n gives tx_valid at cycle n+1.
- FIFO rules:
  - Circular buffers with read/write pointers plus a count of $clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
  - A full FIFO never accepts a push, even with a same-cycle pop; ready is registered-state based.
  - An empty FIFO never presents data in the same cycle it is pushed (no fall-through).
- Reset mid-operation: all FIFO contents and GPRs are dropped immediately; no partial handshakes complete in the reset cycle.
- No state machine beyond the per-FIFO counters. All handshakes are stall-only: no flags, no errors.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-traffic.
  - Required: tx_valid = 0000, rx_ready = 1111, wr_ready = 1 while rst is high; after release, a read of RA (addr 2) gives 0.
- Constants and GPR:
  - Stimulus: write 0x5A to addr 2, then read A = 2, B = 1.
  - Required: 0x5A and 0x01; a write of 0xFF to addr 0 leaves reads of 0 at 0x00.
  - Stimulus: read addr 2 in the same cycle as writing 0x33 to it.
  - Required: old value 0x5A returned.
- Port read stall:
  - Stimulus: rd_valid with A = P2 (addr 5) and an empty FIFO.
  - Required: rd_ready = 0 for 3 cycles; drive rx_valid[1] with 0x7C, then rd_ready = 1 the next cycle with rd_data_a = 0x7C; FIFO empty after consume.
- Dual read of the same port:
  - Stimulus: push 0x11, 0x22 into P1; read A = B = 4.
  - Required: both 0x11; next read gives 0x22 (single pop per read).
- TX backpressure and wrap:
  - Stimulus: tx_ready[3] = 0, write 0xA1, 0xA2, 0xA3 to P4 (addr 7).
  - Required: third write stalls with wr_ready = 0; raise tx_ready and observe 0xA1, 0xA2, 0xA3 in order.
  - Repeat 5 times to cover pointer wrap.
- RX full:
  - Stimulus: push 3 words into P3 with no reads.
  - Required: rx_ready[2] drops after 2; simultaneous pop and push at full does not raise rx_ready until the cycle after the pop.
